ila_capture_ctrl: RTL

//  Capture-side write controller for the ILA sample buffer. Streams probe samples into port A of the
//  512x20 dual-port sample RAM as a circular buffer, with a runtime-programmable pre-trigger depth.

---
 rtl/ila_capture_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ila_capture_ctrl.sv
// ila_capture_ctrl: capture-side write controller for the ILA sample RAM (port A).
// Streams valid samples into a circular buffer and stops DEPTH samples around the trigger.
module ila_capture_ctrl #(
   parameter int P_DATA_WIDTH = 20,
   parameter int P_ADDR_WIDTH = 9,
   parameter int P_COUNT      = 512
) (
   input  logic                    CLK_I,
   input  logic                    RST_I,
   input  logic                    ARM_I,
   input  logic                    ABORT_I,
   input  logic [P_ADDR_WIDTH-1:0] PRETRIG_I,
   input  logic [P_DATA_WIDTH-1:0] SAMPLE_I,
   input  logic                    SAMPLE_VALID_I,
   input  logic                    TRIG_I,
   output logic                    RAM_CS_O,
   output logic                    RAM_WE_O,
   output logic                    RAM_RE_O,
   output logic [P_ADDR_WIDTH-1:0] RAM_ADDR_O,
   output logic [P_DATA_WIDTH-1:0] RAM_DW_O,
   output logic [P_DATA_WIDTH-1:0] RAM_BM_O,
   output logic                    BUSY_O,
   output logic                    DONE_O,
   output logic [P_ADDR_WIDTH-1:0] TRIG_ADDR_O,
   output logic [P_ADDR_WIDTH-1:0] START_ADDR_O
);

   localparam logic [P_ADDR_WIDTH-1:0] LAST = P_ADDR_WIDTH'(P_COUNT - 1);
   localparam logic [P_ADDR_WIDTH-1:0] ONE  = P_ADDR_WIDTH'(1);

   typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, DONE} state_t;

   state_t                  state;
   state_t                  state_next;
   logic [P_ADDR_WIDTH-1:0] wp;
   logic [P_ADDR_WIDTH-1:0] pt;
   logic [P_ADDR_WIDTH-1:0] pre_cnt;
   logic [P_ADDR_WIDTH-1:0] post_cnt;
   logic [P_ADDR_WIDTH-1:0] post_init;
   logic [P_ADDR_WIDTH-1:0] trig_addr;
   logic [P_ADDR_WIDTH-1:0] start_addr;
   logic [P_ADDR_WIDTH-1:0] ram_addr;
   logic [P_DATA_WIDTH-1:0] ram_dw;
   logic                    ram_wr;
   logic                    done;
   logic                    arm_ok;
   logic                    sample_wr;
   logic                    trig_hit;

   // PRETRIG_I is AW bits wide, so it can never exceed DEPTH-1 and is latched as-is.
   assign arm_ok    = ARM_I && !ABORT_I && (state == IDLE || state == DONE);
   assign sample_wr = BUSY_O && SAMPLE_VALID_I && !ABORT_I;
   assign trig_hit  = (state == WAIT_TRIG) && sample_wr && TRIG_I;
   assign post_init = LAST - pt;

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (ABORT_I) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE, DONE: if (ARM_I) state_next = (PRETRIG_I != '0) ? PRE : WAIT_TRIG;
            PRE:        if (sample_wr && (pre_cnt + ONE) == pt) state_next = WAIT_TRIG;
            WAIT_TRIG:  if (trig_hit) state_next = (post_init == '0) ? DONE : POST;
            POST:       if (sample_wr && post_cnt == ONE) state_next = DONE;
            default:    state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      BUSY_O = 1'b0;
      case (state)
         PRE, WAIT_TRIG, POST: BUSY_O = 1'b1;
         default:              BUSY_O = 1'b0;
      endcase
   end

   // DONE_O trails the DONE state by one cycle so it rises after the last write is on the port.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         wp         <= '0;
         pt         <= '0;
         pre_cnt    <= '0;
         post_cnt   <= '0;
         trig_addr  <= '0;
         start_addr <= '0;
         ram_addr   <= '0;
         ram_dw     <= '0;
         ram_wr     <= 1'b0;
         done       <= 1'b0;
      end else begin
         ram_wr <= sample_wr;
         done   <= (state == DONE) && !ABORT_I && !ARM_I;
         if (sample_wr) begin
            ram_addr <= wp;
            ram_dw   <= SAMPLE_I;
            wp       <= wp + ONE;
         end
         if (arm_ok) begin
            pt      <= PRETRIG_I;
            wp      <= '0;
            pre_cnt <= '0;
         end
         if (state == PRE && sample_wr) pre_cnt <= pre_cnt + ONE;
         if (trig_hit) begin
            trig_addr  <= wp;
            start_addr <= wp - pt;
            post_cnt   <= post_init;
         end
         if (state == POST && sample_wr) post_cnt <= post_cnt - ONE;
      end
   end

   assign RAM_CS_O     = ram_wr;
   assign RAM_WE_O     = ram_wr;
   assign RAM_RE_O     = 1'b0;
   assign RAM_ADDR_O   = ram_addr;
   assign RAM_DW_O     = ram_dw;
   assign RAM_BM_O     = {P_DATA_WIDTH{ram_wr}};
   assign DONE_O       = done;
   assign TRIG_ADDR_O  = trig_addr;
   assign START_ADDR_O = start_addr;

endmodule
